// File: rtl/add_pipe.sv
// add_pipe: carry-pipelined adder, one CHUNK-wide carry segment per stage.
// {cout,sum} = a + b + cin, latency STAGES = WIDTH/CHUNK, global stall on out_ready.
// Optional macro ADD_PIPE_OVF_EN adds a registered signed-overflow flag (port ovf).
module add_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    // Whole pipeline moves together; a full output slot blocks everything behind it.
    logic w_advance;

    // Per-stage inputs (from the ports for stage 0, from the previous stage otherwise).
    logic             w_vin   [STAGES];
    logic             w_cin   [STAGES];
    logic [WIDTH-1:0] w_ain   [STAGES];
    logic [WIDTH-1:0] w_bin   [STAGES];
    logic [WIDTH-1:0] w_sin   [STAGES];
    logic [WIDTH-1:0] w_snext [STAGES];
    logic [CHUNK:0]   w_part  [STAGES];

    // Stage registers: valid, chunk carry-out, operands carried forward, partial sum.
    logic             r_v [STAGES];
    logic             r_c [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];

    assign w_advance = !r_v[LAST] || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;
        localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}}) << LO;

        if (k == 0) begin : g_head
            assign w_vin[k] = in_valid;
            assign w_cin[k] = cin;
            assign w_ain[k] = a;
            assign w_bin[k] = b;
            assign w_sin[k] = '0;
        end else begin : g_link
            assign w_vin[k] = r_v[k-1];
            assign w_cin[k] = r_c[k-1];
            assign w_ain[k] = r_a[k-1];
            assign w_bin[k] = r_b[k-1];
            assign w_sin[k] = r_s[k-1];
        end

        // Resolve this stage's chunk and splice it into the partial sum.
        assign w_part[k]  = (CHUNK+1)'(w_ain[k][LO +: CHUNK])
                          + (CHUNK+1)'(w_bin[k][LO +: CHUNK])
                          + (CHUNK+1)'(w_cin[k]);
        assign w_snext[k] = (w_sin[k] & ~CMASK)
                          | (WIDTH'(w_part[k][CHUNK-1:0]) << LO);

        // Stage register: clears on reset, holds on stall, shifts (with bubbles) otherwise.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end else if (w_advance) begin
                r_v[k] <= w_vin[k];
                r_c[k] <= w_part[k][CHUNK];
                r_a[k] <= w_ain[k];
                r_b[k] <= w_bin[k];
                r_s[k] <= w_snext[k];
            end
        end
    end

`ifdef ADD_PIPE_OVF_EN
    logic r_ovf;

    // Signed overflow computed alongside the final chunk so it stays aligned with sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= (w_ain[LAST][WIDTH-1] == w_bin[LAST][WIDTH-1])
                  && (w_snext[LAST][WIDTH-1] != w_ain[LAST][WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: a 16/8 and a 32/8 instance share stimulus; each has its own
// transaction-queue reference model (result visible after STAGES advancing edges).
module tb_add_pipe;

    typedef struct {
        logic [32:0] res;
        logic        ovf;
        int          age;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        cin;

    logic        ir16, ov16, co16;
    logic [15:0] s16;
    logic        ir32, ov32, co32;
    logic [31:0] s32;
`ifdef ADD_PIPE_OVF_EN
    logic        ovf16, ovf32;
`else
    logic        ovf16 = 1'b0;
    logic        ovf32 = 1'b0;
`endif

    int   total = 0;
    int   bad   = 0;
    ent_t q16[$];
    ent_t q32[$];

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(16), .CHUNK(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .a(a32[15:0]), .b(b32[15:0]), .cin(cin),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16)
`ifdef ADD_PIPE_OVF_EN
        , .ovf(ovf16)
`endif
    );

    add_pipe #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32)
`ifdef ADD_PIPE_OVF_EN
        , .ovf(ovf32)
`endif
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input int w, input logic [31:0] x, input logic [31:0] y,
                                input logic c);
        ent_t        e;
        logic [63:0] m;
        logic [63:0] s;
        m     = (64'd1 << w) - 64'd1;
        s     = (64'(x) & m) + (64'(y) & m) + 64'(c);
        e.res = s[32:0];
        e.ovf = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        e.age = 0;
        return e;
    endfunction

    // Compare one DUT against its queue, then advance the queue as the edge will.
    task automatic model_step(input string nm, input int w, input int stages, ref ent_t q[$],
                              input logic iv, input logic ordy,
                              input logic [31:0] x, input logic [31:0] y, input logic c,
                              input logic got_v, input logic got_rdy,
                              input logic [32:0] got_res, input logic got_ovf);
        logic exp_v;
        ent_t e;
        exp_v = (q.size() > 0) && (q[0].age == stages);
        chk({nm, "_out_valid"}, 33'(got_v), 33'(exp_v));
        chk({nm, "_in_ready"}, 33'(got_rdy), 33'(!exp_v || ordy));
        if (exp_v) begin
            chk({nm, "_result"}, got_res, q[0].res);
`ifdef ADD_PIPE_OVF_EN
            chk({nm, "_ovf"}, 33'(got_ovf), 33'(q[0].ovf));
`endif
        end
        if (!exp_v || ordy) begin
            if (exp_v) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (iv) begin
                e     = mk(w, x, y, c);
                e.age = 1;
                q.push_back(e);
            end
        end
    endtask

    // One clock: drive, check both instances, clock edge, settle.
    task automatic cycle(input logic iv, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic ordy);
        in_valid  = iv;
        a32       = x;
        b32       = y;
        cin       = c;
        out_ready = ordy;
        #1;
        model_step("w16", 16, 2, q16, iv, ordy, x, y, c, ov16, ir16, 33'({co16, s16}), ovf16);
        model_step("w32", 32, 4, q32, iv, ordy, x, y, c, ov32, ir32, 33'({co32, s32}), ovf32);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_v16"}, 33'(ov16), 33'd0);
        chk({tag, "_s16"}, 33'({co16, s16}), 33'd0);
        chk({tag, "_v32"}, 33'(ov32), 33'd0);
        chk({tag, "_s32"}, 33'({co32, s32}), 33'd0);
`ifdef ADD_PIPE_OVF_EN
        chk({tag, "_ovf16"}, 33'(ovf16), 33'd0);
`endif
        q16.delete();
        q32.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a32       = '0;
        b32       = '0;
        cin       = 1'b0;
        @(posedge clk);
        do_reset("rst");
        out_ready = 1'b0;
        #1;
        chk("rdy_after_rst16", 33'(ir16), 33'd1);
        chk("rdy_after_rst32", 33'(ir32), 33'd1);

        // Carry across the chunk boundary, latency 2 on the 16-bit instance.
        cycle(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("chunk_carry_v", 33'(ov16), 33'd1);
        chk("chunk_carry_sum", 33'(s16), 33'h0100);
        chk("chunk_carry_cout", 33'(co16), 33'd0);

        // Full wrap with carry-in.
        cycle(1'b1, 32'h0000_FFFF, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("wrap_sum", 33'(s16), 33'h0000);
        chk("wrap_cout", 33'(co16), 33'd1);
`ifdef ADD_PIPE_OVF_EN
        cycle(1'b1, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("ovf_sum", 33'(s16), 33'h8000);
        chk("ovf_flag", 33'(ovf16), 33'd1);
`endif

        // Back-to-back transfers, one result per cycle.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 32'(i), 1'b0, 1'b1);
        chk("b2b_third", 33'(s16), 33'd6);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("b2b_fourth", 33'(s16), 33'd8);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Stall with a result pending; offered inputs during the stall must be ignored.
        cycle(1'b1, 32'd5, 32'd5, 1'b0, 1'b1);
        cycle(1'b1, 32'd6, 32'd6, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        chk("stall_hold_sum", 33'(s16), 33'd10);
        chk("stall_in_ready", 33'(ir16), 33'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Reset with two operand sets in flight: neither may surface.
        cycle(1'b1, 32'd10, 32'd20, 1'b0, 1'b1);
        cycle(1'b1, 32'd30, 32'd40, 1'b0, 1'b1);
        do_reset("mid_rst");
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Random operands with random valid/ready.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1 && ($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'b1 && ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
